fp_addsub_pipe: RTL
===================

Name: fp_addsub_pipe

Overview:
- Parametrised IEEE-754 floating-point add/subtract unit; next generation of the team's single-stage FP32 adder.
- Generic in exponent/mantissa width, with selectable rounding (truncate or round-to-nearest-even) and Inf/NaN handling.
- Fixed 3-stage pipeline with valid/ready handshake and full backpressure.
- Sits in the matrix datapath between operand fetch and accumulator write-back.

Parameters:
EXP_W, 8, exponent field width (≥4)
MAN_W, 23, stored fraction width (≥4); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  unit accepts operands this cycle
sub  in  1  0: y=a+b, 1: y=a-b
rnd  in  1  0: truncate, 1: round-to-nearest-even (RNE)
a  in  W  operand A
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  W  result
overflow  out  1  finite result exceeded max exponent, or an input was Inf
invalid  out  1  Inf−Inf or NaN input
zero  out  1  y is ±0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear. out_valid=0, y=0, overflow=0, invalid=0, zero=0. Stage data need not be reset.
- Pipeline control:
  - advance = !out_valid | out_ready.
  - in_ready = advance (combinational).
  - A transfer happens when in_valid & in_ready.
  - When advance=1, every stage shifts one step. Stage-1 valid loads in_valid & in_ready.
  - When advance=0, all stages hold.
  - Bubbles are not collapsed.
- Latency is exactly 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Outputs y and flags are registered and hold stable while out_valid & !out_ready. Results emerge in acceptance order. No result is lost or duplicated.
- S1, unpack/align:
  - Effective sign of b is b.sign^sub.
  - Exp field 0 is treated as exponent 1 with hidden bit 0 (denormal); otherwise hidden bit 1.
  - Mantissa is extended by 3 bits (guard, round, sticky).
  - The smaller operand is right-shifted by the exponent difference. All bits shifted past sticky are OR-ed into sticky. A shift ≥ MAN_W+3 leaves sticky only.
  - Both operands are registered together with sub/rnd.
- S2, add/sub: magnitude add or subtract.
  - For subtraction, if the result is negative, negate it and take sign_b.
  - Leading-zero count is computed and registered.
- S3, normalize/round/pack:
  - Carry-out: shift right 1 (sticky absorbs), exp+1.
  - Otherwise: shift left by min(lzc, exp−1). A result with exp reaching 1 and hidden bit 0 packs as denormal (exp field 0).
  - rnd=1: increment when G & (R|S|lsb). A mantissa carry from rounding bumps the exponent.
  - rnd=0: discard G/R/S.
  - Exact zero magnitude produces +0 under both modes (including a−a). zero=1.
  - Final exponent ≥ 2^EXP_W−1: y = {sign, all-ones, 0} (Inf), overflow=1.
- Special inputs:
  - Either input has exp all-ones with fraction ≠0 (NaN): y = canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Inf ± finite: Inf of that sign, overflow=1.
  - Inf + Inf of the same effective sign: that Inf, overflow=1.
  - Inf − Inf (effective signs differ): canonical qNaN, invalid=1, overflow=0.
  - Special cases are detected in S1 and carried as tags. They override the S3 arithmetic.
- Simultaneous events: input acceptance and output consumption in the same cycle proceed normally.
- Reset asserted mid-operation discards all in-flight operations. out_valid falls immediately (asynchronously).

Test Plan:
- a=0x3F800000, b=0x40000000, sub=0, rnd=1, out_ready=1 → y=0x40400000 exactly 3 cycles after accept, zero=0, overflow=0.
- a=0x3F800000, b=0x3F800000, sub=1 → y=0x00000000, zero=1. Then a=0x00000001, b=0x00000001, sub=0 → y=0x00000002 (denormal sum).
- a=0x3F800001, b=0x33800000 (tie), sub=0 → rnd=1 gives y=0x3F800002; rnd=0 gives y=0x3F800001.
- a=b=0x7F7FFFFF, sub=0 → y=0x7F800000, overflow=1. a=b=0x7F800000, sub=1 → y=0x7FC00000, invalid=1.
- Stream 6 back-to-back ops with out_ready held low cycles 2–6 → in_ready low while the pipe is full. All 6 results appear in order with y stable during the stall, none dropped or duplicated.
- 3 ops in flight, rst_n pulsed low asynchronously mid-cycle → out_valid=0 at once and no stale result after release. The next op completes in 3 cycles.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Parametrised IEEE-754 add/subtract, three register stages (align, add, normalise/round/pack)
// with a valid/ready handshake where the whole pipe stalls together on backpressure.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic                   rnd,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   overflow,
  output logic                   invalid,
  output logic                   zero
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned LZW = $clog2(MW + 1);
  localparam int unsigned EW1 = EXP_W + 1;
  localparam int unsigned FW2 = MAN_W + 2;

  localparam logic [EXP_W-1:0] ALL1 = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc_f(input logic [MW-1:0] v);
    lzc_f = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if (v[i]) lzc_f = LZW'(MW - 1 - i);
    end
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- S1: unpack / align
  logic             sa, sb, ha, hb, swap;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] ea, eb, e_big, e_diff;
  logic [MW-1:0]    ma, mb, m_big, m_small, m_al;
  logic [2*MW-1:0]  sh_wide;
  logic             spec_d, sinv_d, sovf_d;
  logic [W-1:0]     sy_d;

  always_comb begin
    sa      = a[W-1];
    sb      = b[W-1] ^ sub;
    ha      = |a[W-2:MAN_W];
    hb      = |b[W-2:MAN_W];
    ea      = ha ? a[W-2:MAN_W] : EXP_W'(1);
    eb      = hb ? b[W-2:MAN_W] : EXP_W'(1);
    ma      = {ha, a[MAN_W-1:0], 3'b000};
    mb      = {hb, b[MAN_W-1:0], 3'b000};
    swap    = eb > ea;
    e_big   = swap ? eb : ea;
    e_diff  = swap ? (eb - ea) : (ea - eb);
    m_big   = swap ? mb : ma;
    m_small = swap ? ma : mb;
    sh_wide = '0;
    if (32'(e_diff) >= MW) begin
      m_al = {{(MW-1){1'b0}}, |m_small};
    end else begin
      // Lower half collects everything shifted past the sticky position.
      sh_wide = {m_small, {MW{1'b0}}} >> e_diff;
      m_al    = {sh_wide[2*MW-1:MW+1], sh_wide[MW] | (|sh_wide[MW-1:0])};
    end

    nan_a  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    nan_b  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
    inf_a  = (&a[W-2:MAN_W]) && !(|a[MAN_W-1:0]);
    inf_b  = (&b[W-2:MAN_W]) && !(|b[MAN_W-1:0]);
    spec_d = nan_a || nan_b || inf_a || inf_b;
    sinv_d = nan_a || nan_b || (inf_a && inf_b && (sa != sb));
    sovf_d = spec_d && !sinv_d;
    sy_d   = sinv_d ? QNAN : {(inf_a ? sa : sb), ALL1, {MAN_W{1'b0}}};
  end

  logic             s1_valid_q, s1_sign_big_q, s1_sign_small_q, s1_rnd_q;
  logic             s1_spec_q, s1_inv_q, s1_ovf_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MW-1:0]    s1_m_big_q, s1_m_small_q;
  logic [W-1:0]     s1_sy_q;

  // ---------------------------------------------------------------- S2: add / subtract
  logic [MW:0]    diff, mag_d;
  logic           sign2_d;
  logic [LZW-1:0] lzc_d;

  always_comb begin
    diff    = {1'b0, s1_m_big_q} - {1'b0, s1_m_small_q};
    mag_d   = diff;
    sign2_d = s1_sign_big_q;
    if (s1_sign_big_q == s1_sign_small_q) begin
      mag_d = {1'b0, s1_m_big_q} + {1'b0, s1_m_small_q};
    end else if (diff[MW]) begin
      mag_d   = -diff;
      sign2_d = s1_sign_small_q;
    end
    lzc_d = lzc_f(mag_d[MW-1:0]);
  end

  logic             s2_valid_q, s2_sign_q, s2_rnd_q;
  logic             s2_spec_q, s2_inv_q, s2_ovf_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [MW:0]      s2_mag_q;
  logic [LZW-1:0]   s2_lzc_q;
  logic [W-1:0]     s2_sy_q;

  // ---------------------------------------------------------------- S3: normalise / round / pack
  logic [MW-1:0]  m_n;
  logic [EW1-1:0] e_n, e_r;
  logic [31:0]    lz32, em1, sh;
  logic [FW2-1:0] rounded;
  logic           inc, hid;
  logic [W-1:0]   y_d;
  logic           ovf_d, inv_d, zero_d;

  always_comb begin
    lz32 = 32'(s2_lzc_q);
    em1  = 32'(s2_exp_q) - 32'd1;
    sh   = '0;
    if (s2_mag_q[MW]) begin
      m_n = {s2_mag_q[MW:2], s2_mag_q[1] | s2_mag_q[0]};
      e_n = {1'b0, s2_exp_q} + EW1'(1);
    end else begin
      // Never normalise below exponent 1; what remains unnormalised is a denormal.
      sh  = (lz32 < em1) ? lz32 : em1;
      m_n = s2_mag_q[MW-1:0] << sh;
      e_n = {1'b0, s2_exp_q} - EW1'(sh);
    end
    inc     = s2_rnd_q && m_n[2] && (m_n[1] || m_n[0] || m_n[3]);
    rounded = {1'b0, m_n[MW-1:3]} + FW2'(inc);
    hid     = rounded[MAN_W+1] || rounded[MAN_W];
    e_r     = e_n + EW1'(rounded[MAN_W+1]);

    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_spec_q) begin
      y_d   = s2_sy_q;
      ovf_d = s2_ovf_q;
      inv_d = s2_inv_q;
    end else if (s2_mag_q == '0) begin
      y_d = '0;
    end else if (hid && (e_r >= {1'b0, ALL1})) begin
      y_d   = {s2_sign_q, ALL1, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      y_d = {s2_sign_q, (hid ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}), rounded[MAN_W-1:0]};
    end
    zero_d = !s2_spec_q && !(|y_d[W-2:0]);
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      y          <= '0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
      zero       <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      out_valid  <= s2_valid_q;
      if (s2_valid_q) begin
        y        <= y_d;
        overflow <= ovf_d;
        invalid  <= inv_d;
        zero     <= zero_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sign_big_q   <= swap ? sb : sa;
      s1_sign_small_q <= swap ? sa : sb;
      s1_exp_q        <= e_big;
      s1_m_big_q      <= m_big;
      s1_m_small_q    <= m_al;
      s1_rnd_q        <= rnd;
      s1_spec_q       <= spec_d;
      s1_inv_q        <= sinv_d;
      s1_ovf_q        <= sovf_d;
      s1_sy_q         <= sy_d;
    end
    if (advance && s1_valid_q) begin
      s2_sign_q <= sign2_d;
      s2_exp_q  <= s1_exp_q;
      s2_mag_q  <= mag_d;
      s2_lzc_q  <= lzc_d;
      s2_rnd_q  <= s1_rnd_q;
      s2_spec_q <= s1_spec_q;
      s2_inv_q  <= s1_inv_q;
      s2_ovf_q  <= s1_ovf_q;
      s2_sy_q   <= s1_sy_q;
    end
  end

endmodule
